// File: rtl/fc_mac_scheduler.sv
`default_nettype none
// =============================================================================
// fc_mac_scheduler : 48->10 fully connected layer sequencer driving one shared
//                    MAC against a synchronous weight ROM.      Rev 1.0
// =============================================================================
module fc_mac_scheduler #(
   parameter int IN_BEATS   = 16,
   parameter int INPUT_NUM  = 48,
   parameter int OUTPUT_NUM = 10,
   parameter int DATA_BITS  = 8,
   parameter int ACC_BITS   = 28
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              valid_in,
   input  logic signed [11:0]                data_in_1,
   input  logic signed [11:0]                data_in_2,
   input  logic signed [11:0]                data_in_3,
   output logic                              in_ready,
   output logic                              w_rd_en,
   output logic [8:0]                        w_addr,
   input  logic signed [DATA_BITS-1:0]       w_data,
   input  logic [0:DATA_BITS*OUTPUT_NUM-1]   b_fc,
   output logic [11:0]                       data_out,
   output logic [3:0]                        out_idx,
   output logic                              valid_out,
   output logic                              done
);

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_BIAS  = 2'd3;

   localparam logic [3:0] c_LAST_BEAT  = 4'(IN_BEATS - 1);
   localparam logic [5:0] c_LAST_K     = 6'(INPUT_NUM - 1);
   localparam logic [3:0] c_LAST_CLASS = 4'(OUTPUT_NUM - 1);
   localparam int         c_PROD_BITS  = DATA_BITS + 14;

   logic [1:0]                r_state;
   logic [1:0]                w_next_state;
   logic [3:0]                r_beat;
   logic [5:0]                r_k;
   logic [5:0]                r_k_d;
   logic                      r_acc_vld;
   logic [3:0]                r_class;
   logic [ACC_BITS-1:0]       r_acc;
   logic signed [13:0]        r_buf [0:INPUT_NUM-1];

   logic [8:0]                w_mac_addr;
   logic [13:0]               w_feat;
   logic [c_PROD_BITS-1:0]    w_wext;
   logic [c_PROD_BITS-1:0]    w_fext;
   logic [c_PROD_BITS-1:0]    w_prod;
   logic [ACC_BITS-1:0]       w_prod_ext;
   logic [DATA_BITS-1:0]      w_bias;
   logic [11:0]               w_score;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FILL: begin
            if (valid_in && (r_beat == c_LAST_BEAT)) begin
               w_next_state = S_MAC;
            end
         end
         S_MAC: begin
            if (r_k == c_LAST_K) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_next_state = S_BIAS;
         end
         S_BIAS: begin
            w_next_state = (r_class == c_LAST_CLASS) ? S_FILL : S_MAC;
         end
         default: begin
            w_next_state = S_FILL;
         end
      endcase
   end

   // ------------------------------------------------------------- FSM outputs
   assign w_mac_addr = {r_class, 5'b0_0000} + {1'b0, r_class, 4'b0000} + {3'b000, r_k};

   always_comb begin
      in_ready = (r_state == S_FILL);
      w_rd_en  = (r_state == S_MAC);
      w_addr   = '0;
      if (r_state == S_MAC) begin
         w_addr = w_mac_addr;
      end
   end

   // ------------------------------------------------------------ feature store
   always_ff @(posedge clk) begin
      if (!rst && (r_state == S_FILL) && valid_in) begin
         r_buf[{2'b00, r_beat}] <= {{2{data_in_1[11]}}, data_in_1};
         r_buf[{2'b01, r_beat}] <= {{2{data_in_2[11]}}, data_in_2};
         r_buf[{2'b10, r_beat}] <= {{2{data_in_3[11]}}, data_in_3};
      end
   end

   // ------------------------------------------------------------- MAC datapath
   // Operands are sign-extended to the full product width so the low bits of
   // a plain multiply equal the signed product.
   assign w_feat     = r_buf[r_k_d];
   assign w_wext     = {{(c_PROD_BITS-DATA_BITS){w_data[DATA_BITS-1]}}, w_data};
   assign w_fext     = {{(c_PROD_BITS-14){w_feat[13]}}, w_feat};
   assign w_prod     = w_wext * w_fext;
   assign w_prod_ext = {{(ACC_BITS-c_PROD_BITS){w_prod[c_PROD_BITS-1]}}, w_prod};
   assign w_bias     = b_fc[{r_class, 3'b000} +: DATA_BITS];
   assign w_score    = 12'((r_acc[18:0] + {{(19-DATA_BITS){w_bias[DATA_BITS-1]}}, w_bias}) >> 7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat    <= '0;
         r_k       <= '0;
         r_k_d     <= '0;
         r_acc_vld <= 1'b0;
         r_class   <= '0;
         r_acc     <= '0;
         data_out  <= '0;
         out_idx   <= '0;
         valid_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         done      <= 1'b0;
         // w_data lags the address by one cycle, so the product uses the
         // feature index issued on the previous MAC cycle.
         r_acc_vld <= (r_state == S_MAC);
         r_k_d     <= r_k;
         case (r_state)
            S_FILL: begin
               if (valid_in) begin
                  r_beat <= (r_beat == c_LAST_BEAT) ? 4'd0 : r_beat + 4'd1;
               end
            end
            S_MAC: begin
               r_k <= (r_k == c_LAST_K) ? 6'd0 : r_k + 6'd1;
            end
            S_BIAS: begin
               data_out  <= w_score;
               out_idx   <= r_class;
               valid_out <= 1'b1;
               if (r_class == c_LAST_CLASS) begin
                  done    <= 1'b1;
                  r_class <= '0;
               end else begin
                  r_class <= r_class + 4'd1;
               end
            end
            default: begin
            end
         endcase
         if (r_state == S_BIAS) begin
            r_acc <= '0;
         end else if (r_acc_vld) begin
            r_acc <= r_acc + w_prod_ext;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_scheduler.sv
`default_nettype none
// tb_fc_mac_scheduler : frames scored against a plain-arithmetic dot-product
// model through an expected-result queue; a monitor pops on every valid_out.
module tb_fc_mac_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic [11:0] data_in_1 = '0;
   logic [11:0] data_in_2 = '0;
   logic [11:0] data_in_3 = '0;
   logic        in_ready;
   logic        w_rd_en;
   logic [8:0]  w_addr;
   logic [7:0]  w_data = '0;
   logic [0:79] b_fc;
   logic [11:0] data_out;
   logic [3:0]  out_idx;
   logic        valid_out;
   logic        done;

   typedef struct {
      int idx;
      int data;
      int t15;
   } exp_t;

   exp_t       q[$];
   int         feat [48];
   logic [7:0] rom  [480];
   logic [7:0] bias [10];
   int         cyc    = 0;
   int         t15    = 0;
   int         n_cmp  = 0;
   int         n_err  = 0;
   bit         active = 1'b0;

   fc_mac_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in_1 (data_in_1),
      .data_in_2 (data_in_2),
      .data_in_3 (data_in_3),
      .in_ready  (in_ready),
      .w_rd_en   (w_rd_en),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .b_fc      (b_fc),
      .data_out  (data_out),
      .out_idx   (out_idx),
      .valid_out (valid_out),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous weight ROM: data one cycle after the read strobe
   always @(posedge clk) begin
      if (w_rd_en) w_data <= rom[w_addr];
   end

   always_comb begin
      for (int i = 0; i < 10; i++) b_fc[8*i +: 8] = bias[i];
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // reference: dot product + bias, then take bits [18:7] of the exact sum
   task automatic push_expected();
      for (int c = 0; c < 10; c++) begin
         int          s;
         logic [31:0] v;
         s = int'($signed(bias[c]));
         for (int f = 0; f < 48; f++) s += feat[f] * int'($signed(rom[c*48+f]));
         v = s;
         q.push_back('{c, int'(v[18:7]), t15});
      end
   endtask

   task automatic fill_feat(input int v);
      for (int f = 0; f < 48; f++) feat[f] = v;
   endtask

   task automatic fill_rom(input int v);
      for (int i = 0; i < 480; i++) rom[i] = 8'(v);
   endtask

   task automatic fill_bias(input int v);
      for (int i = 0; i < 10; i++) bias[i] = 8'(v);
   endtask

   task automatic randomize_frame();
      for (int f = 0; f < 48; f++) feat[f] = int'($signed(12'($urandom)));
      for (int i = 0; i < 480; i++) rom[i] = 8'($urandom);
      for (int i = 0; i < 10; i++) bias[i] = 8'($urandom);
   endtask

   // called at a negedge with in_ready expected high
   task automatic send_frame();
      for (int b = 0; b < 16; b++) begin
         chk("in_ready_fill", int'(in_ready), 1);
         valid_in  = 1'b1;
         data_in_1 = 12'(feat[b]);
         data_in_2 = 12'(feat[16+b]);
         data_in_3 = 12'(feat[32+b]);
         @(negedge clk);
      end
      valid_in = 1'b0;
      t15      = cyc;
      push_expected();
      active   = 1'b1;
   endtask

   task automatic wait_done(input bit garbage);
      int n;
      n = 0;
      while (!done && n < 600) begin
         if (garbage && !in_ready) begin
            valid_in  = ($urandom_range(0, 3) != 0);
            data_in_1 = 12'($urandom);
            data_in_2 = 12'($urandom);
            data_in_3 = 12'($urandom);
         end else begin
            valid_in = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      valid_in = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done after %0d cycles, required within 600", n);
      end
   endtask

   // monitor: scoreboard pops plus per-cycle ROM-strobe timing model
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_out) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stray_pulse: got valid_out idx %0d data 0x%0h, required no pulse",
                        out_idx, data_out);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("score",   int'(data_out), e.data);
               chk("out_idx", int'(out_idx),  e.idx);
               chk("done",    int'(done),     (e.idx == 9) ? 1 : 0);
               chk("latency", cyc - e.t15,    50 * (e.idx + 1));
               if (e.idx == 9) active = 1'b0;
            end
         end else if (done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_alone: got done=1 with valid_out=0, required done only with class 9");
         end
         if (active) begin
            int d;
            d = cyc - t15;
            chk("in_ready_busy", int'(in_ready), 0);
            chk("w_rd_en", int'(w_rd_en), ((d % 50) < 48) ? 1 : 0);
            if ((d % 50) < 48) chk("w_addr", int'(w_addr), (d / 50) * 48 + (d % 50));
         end
         if (!w_rd_en) chk("w_addr_idle", int'(w_addr), 0);
      end
   end

   initial begin
      int n;
      fill_feat(0);
      fill_rom(0);
      fill_bias(0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data_out",  int'(data_out),  0);
      chk("rst_out_idx",   int'(out_idx),   0);
      chk("rst_valid_out", int'(valid_out), 0);
      chk("rst_done",      int'(done),      0);
      chk("rst_w_rd_en",   int'(w_rd_en),   0);
      chk("rst_w_addr",    int'(w_addr),    0);
      chk("rst_in_ready",  int'(in_ready),  1);
      rst = 1'b0;
      @(negedge clk);

      // all 128, unit weights -> 48 everywhere
      fill_feat(128); fill_rom(1); fill_bias(0);
      send_frame(); wait_done(1'b0);

      // same frame with garbage beats hammered in during compute
      send_frame(); wait_done(1'b1);

      // -128 features, only class 3 weighted
      fill_feat(-128); fill_rom(0); fill_bias(0);
      for (int f = 0; f < 48; f++) rom[3*48+f] = 8'd1;
      send_frame(); wait_done(1'b0);

      // large positive sum wrapping above bit 18
      fill_feat(2047); fill_rom(127); fill_bias(0);
      send_frame(); wait_done(1'b0);

      // bias only: +127 even classes, -128 odd classes
      fill_feat(0); fill_rom(0);
      for (int i = 0; i < 10; i++) bias[i] = (i % 2 == 0) ? 8'sd127 : -8'sd128;
      send_frame(); wait_done(1'b0);

      for (int r = 0; r < 2; r++) begin
         randomize_frame();
         send_frame(); wait_done(1'b1);
      end

      // abort a frame during class 4
      randomize_frame();
      send_frame();
      n = 0;
      while (cyc < t15 + 220 && n < 400) begin
         @(negedge clk);
         n++;
      end
      #2;
      rst    = 1'b1;
      active = 1'b0;
      #1;
      chk("abort_data_out",  int'(data_out),  0);
      chk("abort_out_idx",   int'(out_idx),   0);
      chk("abort_valid_out", int'(valid_out), 0);
      chk("abort_done",      int'(done),      0);
      chk("abort_in_ready",  int'(in_ready),  1);
      chk("abort_w_rd_en",   int'(w_rd_en),   0);
      chk("abort_pending",   q.size(),        6);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      fill_feat(128); fill_rom(1); fill_bias(0);
      send_frame(); wait_done(1'b0);
      randomize_frame();
      send_frame(); wait_done(1'b0);

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
